// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter and the core
// that drives it: arbiter state encoding, grant owner, write-section codes.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FETCH_BUSY = 2'd1,
        ST_DATA_BUSY  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam logic [2:0] WS_READ    = 3'b000;
    localparam logic [2:0] WS_BYTE0   = 3'b001;
    localparam logic [2:0] WS_BYTE1   = 3'b010;
    localparam logic [2:0] WS_HALF_HI = 3'b100;
    localparam logic [2:0] WS_WORD    = 3'b111;

    function automatic logic is_write(input logic [2:0] sections);
        return sections != WS_READ;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetch and load/store ports onto one single-port
// memory, with optional round-robin priority and an acknowledge timeout.
//
// state         | meaning
// ST_IDLE       | no transaction, grant on any request
// ST_FETCH_BUSY | fetch transaction outstanding toward memory
// ST_DATA_BUSY  | load/store transaction outstanding toward memory
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    output logic        fetch_ready,
    output logic [31:0] fetch_data,
    input  logic        data_request,
    input  logic [31:0] data_address,
    input  logic [2:0]  data_write_sections,
    input  logic [31:0] data_write_value,
    output logic        data_ready,
    output logic [31:0] data_read_value,
    output logic        memory_request,
    output logic [31:0] memory_address,
    output logic [31:0] memory_write_value,
    output logic [2:0]  memory_write_sections,
    input  logic [31:0] memory_read_value,
    input  logic        memory_acknowledge,
    output logic        bus_error
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t  state;
    arb_state_t  next_state;
    grant_t      last_grant;
    logic [15:0] timeout_count;
    logic        grant_fetch;
    logic        grant_data;
    logic        timed_out;
    logic        complete;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            last_grant    <= GRANT_DATA;
            timeout_count <= 16'd0;
        end else begin
            state <= next_state;
            if (grant_fetch || grant_data) begin
                timeout_count <= 16'd0;
            end else if (state != ST_IDLE && !complete) begin
                timeout_count <= timeout_count + 16'd1;
            end
            if (complete) begin
                last_grant <= (state == ST_FETCH_BUSY) ? GRANT_FETCH : GRANT_DATA;
            end
        end
    end

    always_comb begin
        next_state  = state;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        timed_out   = 1'b0;
        complete    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_request && data_request) begin
                    // Fixed priority always favours the data port.
                    if (ROUND_ROBIN != 0 && last_grant == GRANT_DATA) begin
                        grant_fetch = 1'b1;
                    end else begin
                        grant_data = 1'b1;
                    end
                end else if (fetch_request) begin
                    grant_fetch = 1'b1;
                end else if (data_request) begin
                    grant_data = 1'b1;
                end
                if (grant_fetch) begin
                    next_state = ST_FETCH_BUSY;
                end else if (grant_data) begin
                    next_state = ST_DATA_BUSY;
                end
            end
            ST_FETCH_BUSY, ST_DATA_BUSY: begin
                timed_out = !memory_acknowledge && (timeout_count == TIMEOUT_LAST);
                complete  = memory_acknowledge || timed_out;
                if (complete) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        memory_request = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memory_address        <= 32'd0;
            memory_write_value    <= 32'd0;
            memory_write_sections <= WS_READ;
            fetch_ready           <= 1'b0;
            fetch_data            <= 32'd0;
            data_ready            <= 1'b0;
            data_read_value       <= 32'd0;
            bus_error             <= 1'b0;
        end else begin
            fetch_ready <= complete && (state == ST_FETCH_BUSY);
            data_ready  <= complete && (state == ST_DATA_BUSY);
            bus_error   <= timed_out;
            if (grant_fetch) begin
                memory_address        <= fetch_address;
                memory_write_value    <= 32'd0;
                memory_write_sections <= WS_READ;
            end else if (grant_data) begin
                memory_address        <= data_address;
                memory_write_value    <= data_write_value;
                memory_write_sections <= data_write_sections;
            end
            if (complete && state == ST_FETCH_BUSY) begin
                fetch_data <= memory_acknowledge ? memory_read_value : 32'd0;
            end
            // Stores and timed-out accesses report zero on the load path.
            if (complete && state == ST_DATA_BUSY) begin
                data_read_value <= (memory_acknowledge && !is_write(memory_write_sections))
                                   ? memory_read_value : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a round-robin instance with a short
// timeout and a fixed-priority instance share one set of inputs.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        data_request;
    logic [31:0] data_address;
    logic [2:0]  data_write_sections;
    logic [31:0] data_write_value;
    logic [31:0] memory_read_value;
    logic        memory_acknowledge;

    logic        a_fetch_ready, a_data_ready, a_memory_request, a_bus_error;
    logic [31:0] a_fetch_data, a_data_read_value, a_memory_address, a_memory_write_value;
    logic [2:0]  a_memory_write_sections;
    logic        b_fetch_ready, b_data_ready, b_memory_request, b_bus_error;
    logic [31:0] b_fetch_data, b_data_read_value, b_memory_address, b_memory_write_value;
    logic [2:0]  b_memory_write_sections;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset),
        .fetch_request(fetch_request), .fetch_address(fetch_address),
        .fetch_ready(a_fetch_ready), .fetch_data(a_fetch_data),
        .data_request(data_request), .data_address(data_address),
        .data_write_sections(data_write_sections), .data_write_value(data_write_value),
        .data_ready(a_data_ready), .data_read_value(a_data_read_value),
        .memory_request(a_memory_request), .memory_address(a_memory_address),
        .memory_write_value(a_memory_write_value),
        .memory_write_sections(a_memory_write_sections),
        .memory_read_value(memory_read_value), .memory_acknowledge(memory_acknowledge),
        .bus_error(a_bus_error)
    );

    memory_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(255)) dut_b (
        .clk(clk), .reset(reset),
        .fetch_request(fetch_request), .fetch_address(fetch_address),
        .fetch_ready(b_fetch_ready), .fetch_data(b_fetch_data),
        .data_request(data_request), .data_address(data_address),
        .data_write_sections(data_write_sections), .data_write_value(data_write_value),
        .data_ready(b_data_ready), .data_read_value(b_data_read_value),
        .memory_request(b_memory_request), .memory_address(b_memory_address),
        .memory_write_value(b_memory_write_value),
        .memory_write_sections(b_memory_write_sections),
        .memory_read_value(memory_read_value), .memory_acknowledge(memory_acknowledge),
        .bus_error(b_bus_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        fetch_request       = 1'b0;
        fetch_address       = 32'd0;
        data_request        = 1'b0;
        data_address        = 32'd0;
        data_write_sections = 3'b000;
        data_write_value    = 32'd0;
        memory_read_value   = 32'd0;
        memory_acknowledge  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (a_memory_request !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_memory_request: got %0b expected 0", a_memory_request);
        end
        vectors++;
        if ({a_fetch_ready, a_data_ready, a_bus_error} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_pulses: got %03b expected 000", {a_fetch_ready, a_data_ready, a_bus_error});
        end
        vectors++;
        if ({a_fetch_data, a_data_read_value, a_memory_address, a_memory_write_value} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0", a_fetch_data,
                     a_data_read_value, a_memory_address, a_memory_write_value);
        end
        vectors++;
        if (a_memory_write_sections !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_sections: got %03b expected 000", a_memory_write_sections);
        end
        vectors++;
        if ({b_memory_request, b_fetch_ready, b_data_ready, b_bus_error} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_b_controls: got %04b expected 0000",
                     {b_memory_request, b_fetch_ready, b_data_ready, b_bus_error});
        end
    endtask

    task automatic test_fetch_only();
        int pulses;
        do_reset();
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0100;
        tick();
        fetch_request = 1'b0;
        vectors++;
        if (a_memory_request !== 1'b1 || a_memory_address !== 32'h100 || a_memory_write_sections !== 3'b000) begin
            miscompares++;
            $display("FAIL fetch_grant: got req=%0b addr=%h ws=%03b expected req=1 addr=00000100 ws=000",
                     a_memory_request, a_memory_address, a_memory_write_sections);
        end
        pulses = 0;
        tick();
        pulses += int'(a_fetch_ready);
        tick();
        pulses += int'(a_fetch_ready);
        vectors++;
        if (a_memory_request !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_hold_request: got %0b expected 1", a_memory_request);
        end
        memory_acknowledge = 1'b1;
        memory_read_value  = 32'h0000_0013;
        tick();
        pulses += int'(a_fetch_ready);
        memory_acknowledge = 1'b0;
        memory_read_value  = 32'hFFFF_FFFF;
        vectors++;
        if (a_fetch_ready !== 1'b1 || a_fetch_data !== 32'h13 || a_memory_request !== 1'b0 || a_data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_complete: got rdy=%0b data=%h req=%0b drdy=%0b expected rdy=1 data=00000013 req=0 drdy=0",
                     a_fetch_ready, a_fetch_data, a_memory_request, a_data_ready);
        end
        tick();
        pulses += int'(a_fetch_ready);
        tick();
        pulses += int'(a_fetch_ready);
        vectors++;
        if (pulses !== 1 || a_fetch_data !== 32'h13) begin
            miscompares++;
            $display("FAIL fetch_single_pulse: got pulses=%0d data=%h expected pulses=1 data=00000013",
                     pulses, a_fetch_data);
        end
    endtask

    task automatic test_ack_in_idle();
        memory_acknowledge = 1'b1;
        memory_read_value  = 32'hCAFE_0000;
        tick();
        tick();
        memory_acknowledge = 1'b0;
        vectors++;
        if ({a_fetch_ready, a_data_ready, a_memory_request, a_bus_error} !== 4'b0000 || a_fetch_data !== 32'h13) begin
            miscompares++;
            $display("FAIL idle_ack_ignored: got flags=%04b fdata=%h expected flags=0000 fdata=00000013",
                     {a_fetch_ready, a_data_ready, a_memory_request, a_bus_error}, a_fetch_data);
        end
    endtask

    task automatic test_store_byte();
        do_reset();
        data_request        = 1'b1;
        data_address        = 32'h0000_2003;
        data_write_sections = 3'b001;
        data_write_value    = 32'h0000_00AB;
        tick();
        data_request        = 1'b0;
        data_address        = 32'h0000_7777;
        data_write_sections = 3'b111;
        data_write_value    = 32'h1111_1111;
        vectors++;
        if (a_memory_request !== 1'b1 || a_memory_address !== 32'h2003 ||
            a_memory_write_sections !== 3'b001 || a_memory_write_value !== 32'hAB) begin
            miscompares++;
            $display("FAIL store_grant: got req=%0b addr=%h ws=%03b val=%h expected 1 00002003 001 000000ab",
                     a_memory_request, a_memory_address, a_memory_write_sections, a_memory_write_value);
        end
        tick();
        tick();
        vectors++;
        if (a_memory_request !== 1'b1 || a_memory_address !== 32'h2003 ||
            a_memory_write_sections !== 3'b001 || a_memory_write_value !== 32'hAB || a_data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL store_stable: got req=%0b addr=%h ws=%03b val=%h rdy=%0b expected 1 00002003 001 000000ab 0",
                     a_memory_request, a_memory_address, a_memory_write_sections,
                     a_memory_write_value, a_data_ready);
        end
        memory_acknowledge = 1'b1;
        memory_read_value  = 32'hDEAD_BEEF;
        tick();
        memory_acknowledge = 1'b0;
        vectors++;
        if (a_data_ready !== 1'b1 || a_data_read_value !== 32'd0 || a_bus_error !== 1'b0 || a_fetch_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL store_complete: got rdy=%0b value=%h err=%0b frdy=%0b expected rdy=1 value=0 err=0 frdy=0",
                     a_data_ready, a_data_read_value, a_bus_error, a_fetch_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        do_reset();
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0F00;
        data_request  = 1'b1;
        data_address  = 32'h0000_0D00;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 32'h0000_0F00 : 32'h0000_0D00;
            tick();
            vectors++;
            if (a_memory_request !== 1'b1 || a_memory_address !== exp_addr) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got req=%0b addr=%h expected req=1 addr=%h",
                         i, a_memory_request, a_memory_address, exp_addr);
            end
            memory_acknowledge = 1'b1;
            memory_read_value  = 32'h100 + 32'(i);
            tick();
            memory_acknowledge = 1'b0;
            vectors++;
            if (a_fetch_ready !== (i % 2 == 0) || a_data_ready !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL rr_ready_%0d: got frdy=%0b drdy=%0b expected frdy=%0b drdy=%0b",
                         i, a_fetch_ready, a_data_ready, (i % 2 == 0), (i % 2 == 1));
            end
        end
        fetch_request = 1'b0;
        data_request  = 1'b0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0F00;
        data_request  = 1'b1;
        data_address  = 32'h0000_0D00;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (b_memory_request !== 1'b1 || b_memory_address !== 32'h0D00) begin
                miscompares++;
                $display("FAIL fixed_grant_%0d: got req=%0b addr=%h expected req=1 addr=00000d00",
                         i, b_memory_request, b_memory_address);
            end
            memory_acknowledge = 1'b1;
            memory_read_value  = 32'h5A5A_0000 + 32'(i);
            tick();
            memory_acknowledge = 1'b0;
            vectors++;
            if (b_data_ready !== 1'b1 || b_fetch_ready !== 1'b0 || b_data_read_value !== 32'h5A5A_0000 + 32'(i)) begin
                miscompares++;
                $display("FAIL fixed_ready_%0d: got drdy=%0b frdy=%0b value=%h expected 1 0 %h",
                         i, b_data_ready, b_fetch_ready, b_data_read_value, 32'h5A5A_0000 + 32'(i));
            end
        end
        fetch_request = 1'b0;
        data_request  = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        data_request        = 1'b1;
        data_address        = 32'h0000_0040;
        data_write_sections = 3'b000;
        tick();
        data_request       = 1'b0;
        memory_acknowledge = 1'b1;
        memory_read_value  = 32'h1234_5678;
        tick();
        memory_acknowledge = 1'b0;
        vectors++;
        if (a_data_ready !== 1'b1 || a_data_read_value !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL load_complete: got rdy=%0b value=%h expected rdy=1 value=12345678",
                     a_data_ready, a_data_read_value);
        end
        tick();
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (a_data_ready !== 1'b0 || a_bus_error !== 1'b0 || a_memory_request !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout_wait_%0d: got rdy=%0b err=%0b req=%0b expected 0 0 1",
                         i, a_data_ready, a_bus_error, a_memory_request);
            end
        end
        tick();
        vectors++;
        if (a_data_ready !== 1'b1 || a_bus_error !== 1'b1 || a_data_read_value !== 32'd0 ||
            a_memory_request !== 1'b0 || a_fetch_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_fire: got rdy=%0b err=%0b value=%h req=%0b frdy=%0b expected 1 1 0 0 0",
                     a_data_ready, a_bus_error, a_data_read_value, a_memory_request, a_fetch_ready);
        end
        tick();
        vectors++;
        if (a_data_ready !== 1'b0 || a_bus_error !== 1'b0 || a_data_read_value !== 32'd0) begin
            miscompares++;
            $display("FAIL timeout_after: got rdy=%0b err=%0b value=%h expected 0 0 0",
                     a_data_ready, a_bus_error, a_data_read_value);
        end
    endtask

    task automatic test_reset_mid_transaction();
        int pulses;
        do_reset();
        data_request = 1'b1;
        data_address = 32'h0000_0300;
        tick();
        data_request = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (a_memory_request !== 1'b0 || a_memory_address !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_drop: got req=%0b addr=%h expected req=0 addr=0",
                     a_memory_request, a_memory_address);
        end
        pulses = 0;
        memory_acknowledge = 1'b1;
        tick();
        pulses += int'(a_data_ready);
        reset              = 1'b0;
        memory_acknowledge = 1'b0;
        tick();
        pulses += int'(a_data_ready);
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL midreset_no_ready: got %0d pulses expected 0", pulses);
        end
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0F00;
        data_request  = 1'b1;
        data_address  = 32'h0000_0D00;
        tick();
        fetch_request = 1'b0;
        data_request  = 1'b0;
        vectors++;
        if (a_memory_request !== 1'b1 || a_memory_address !== 32'h0F00) begin
            miscompares++;
            $display("FAIL midreset_next_grant: got req=%0b addr=%h expected req=1 addr=00000f00",
                     a_memory_request, a_memory_address);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_ack_in_idle();
        test_store_byte();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_reset_mid_transaction();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
